turbo_intlv_buf: RTL
====================

# turbo_intlv_buf

Bank-organised interleaver buffer that sits directly downstream of the turbo length/enable generator. It consumes the per-bank `enable` mask, `id_offset` write address, `wen` strobe and block-complete pulse. It scatters 16 lanes of encoder data into 16 single-bit banks. Once the block is complete, it drains the stored bits serially in interleaved order under a valid/ready handshake.

## Interface
- `BANKS`, 16, number of banks; equals the width of `enable`.
- `DEPTH`, 64, bits per bank; `AW` = log2(`DEPTH`) = 6.
- `LEN_W`, 13, width of `m_len`.
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `din` in 16: lane data; bit b targets bank b.
- `enable` in 16: per-bank write mask from the enable generator.
- `id_offset` in 16: write address; bits [5:0] are used, and bits [15:6] must be zero.
- `wen` in 1: write strobe.
- `blk_done` in 1: one-cycle block-complete pulse; this is the generator's `dout_vld`.
- `m_len` in 13: block length in bits; sampled when `blk_done` is high.
- `dout` out 1: serial interleaved bit.
- `dout_vld` out 1: `dout` is valid.
- `dout_rdy` in 1: downstream accepts `dout` this cycle.
- `dout_last` out 1: marks the final bit of the block; qualified by `dout_vld`.
- `busy` out 1: high while in DRAIN.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- **States.** FILL (reset state) and DRAIN.
- **Writing in FILL.**
  - When `wen`=1, every bank b with `enable[b]`=1 takes `mem[b][id_offset[5:0]] <= din[b]`.
  - Banks with `enable[b]`=0 are unchanged.
  - If `wen`=1 and `id_offset[15:6]`≠0, the write is dropped and `err` is set.
- **Leaving FILL.**
  - When `blk_done`=1 in FILL, latch `m_len` into `len_q` and move to DRAIN.
  - If `wen` is also high in that cycle, that write is still performed.
  - If `m_len`=0 or `m_len`>`BANKS*DEPTH` (1024), set `err` and stay in FILL.
- **Readout in DRAIN.**
  - A read index `rd_idx` counts 0..`len_q`-1.
  - Bank = `rd_idx[3:0]`, address = `rd_idx[9:4]`.
  - Readout is therefore row-major: all 16 banks at address 0, then all 16 at address 1, and so on.
- **Output register.**
  - A single output register holds `dout`, `dout_vld` and `dout_last`.
  - `rd_idx` advances when the output register is empty or is being accepted (`dout_vld & dout_rdy`).
- **End of block.**
  - `dout_last`=1 when the registered bit came from `rd_idx` = `len_q`-1.
  - When the last bit is accepted, return to FILL.
  - Memory is not cleared; the next block overwrites it.
- **Protocol violations in DRAIN.**
  - Any `wen` or `blk_done` received in DRAIN is ignored and sets `err`.
  - The drain in progress continues unaffected.

## Timing
- **Reset values.** `dout`=0, `dout_vld`=0, `dout_last`=0, `busy`=0, `err`=0, state=FILL, `rd_idx`=0. Memory contents are undefined; memory needs no reset.
- **Write latency.** A write is visible to a read one cycle after `wen`.
- **Drain start.** With `blk_done` at cycle t: `busy`=1 at t+1, first `dout_vld` at t+2.
- **Throughput.** With `dout_rdy` held high, one bit per cycle and no bubbles. `dout_vld` is high for exactly `len_q` consecutive cycles.
- **Stall.** With `dout_rdy`=0, `dout`, `dout_vld` and `dout_last` hold stable and `rd_idx` does not advance.
- **Exit.** `dout_last` accepted at cycle u gives `busy`=0 and `dout_vld`=0 at u+1. FILL writes are accepted from u+1.
- **Reset mid-operation.** Asserting `n_rst` low aborts immediately: `dout_vld` drops asynchronously and the state returns to FILL.

## Structure
- **Shared package `turbo_pkg`.** Holds `BANKS`, `DEPTH`, `AW`, `LEN_W`, `MAX_LEN`=1024, and the state encoding (FILL=1'b0, DRAIN=1'b1).
- **Sub-module `intlv_bank`.**
  - One 1-bit x `DEPTH` register-file bank, instantiated `BANKS` times.
  - Ports: clk, `we`, `waddr`, `wbit`, `raddr`, `rbit` (combinational read).
- **Top level.** The FSM, `rd_idx` counter, `len_q` latch, 16:1 read mux, output register and error logic.

## Test plan
- **Single write/readback.** `wen` with `enable`=16'hFFFF, `id_offset`=0, `din`=16'hA5C3, then `blk_done` with `m_len`=16. Required: 16 bits out, LSB (bank 0) first, i.e. 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `dout_last` only on the 16th bit; first `dout_vld` two cycles after `blk_done`.
- **Masked scatter.** Write address 3 with `enable`=16'h00F0 and `din`=16'hFFFF over a prior all-zero fill, then drain with `m_len`=64. Required: only bits 52..55 are 1.
- **Backpressure.** Drain `m_len`=40 with `dout_rdy` toggling 1,0,0,1… Required: exactly 40 accepted bits in index order, output stable while stalled, and `busy` falls the cycle after the last bit is accepted.
- **Errors.**
  - `blk_done` with `m_len`=0: `err`=1 and the block stays in FILL.
  - `blk_done` with `m_len`=1025: `err`=1 and the block stays in FILL.
  - `id_offset`=16'h0040 with `wen`: `err`=1 and the memory is unchanged.
  - `wen` during DRAIN: `err`=1 and the drain data is unchanged.
- **Boundary.** Full 1024-bit block with `m_len`=1024: the last bit is read from bank 15, address 63. Simultaneous `wen` and `blk_done`: the final write appears in the drained data.
- **Reset mid-drain.** `n_rst` low at bit 10 of 32: all outputs go to 0. A new block after reset drains correctly.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared sizing and state encoding for the turbo interleaver buffer.
package turbo_pkg;
    localparam int BANKS   = 16;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int LEN_W   = 13;
    localparam int MAX_LEN = BANKS * DEPTH;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/intlv_bank.sv
// One single-bit register-file bank: synchronous write, combinational read.
module intlv_bank
    import turbo_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wbit,
    input  logic [AW-1:0] raddr,
    output logic          rbit
);
    logic [DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wbit;
    end

    assign rbit = mem[raddr];
endmodule

// File: rtl/turbo_intlv_buf.sv
// Bank-organised interleaver buffer: scatter-writes 16 lanes, then drains
// the block serially in row-major bank order under valid/ready.
//
//   state | meaning
//   FILL  | accept lane writes; wait for a valid block-complete pulse
//   DRAIN | stream len_q bits out; writes and block pulses are errors
module turbo_intlv_buf
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [BANKS-1:0] din,
    input  logic [BANKS-1:0] enable,
    input  logic [15:0]      id_offset,
    input  logic             wen,
    input  logic             blk_done,
    input  logic [LEN_W-1:0] m_len,
    output logic             dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             dout_last,
    output logic             busy,
    output logic             err
);
    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_idx;
    logic [BANKS-1:0] bank_rbit;
    logic             offset_ok, len_ok, wr_ok, start, take, more, accept_last;
    logic             rd_bit;

    assign offset_ok   = (id_offset[15:AW] == '0);
    assign len_ok      = (m_len != '0) && (m_len <= LEN_W'(MAX_LEN));
    assign wr_ok       = (state == FILL) && wen && offset_ok;
    assign start       = (state == FILL) && blk_done && len_ok;
    assign take        = (state == DRAIN) && (!dout_vld || dout_rdy);
    assign more        = (rd_idx < len_q);
    assign accept_last = dout_vld && dout_rdy && dout_last;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        intlv_bank u_bank (
            .clk   (clk),
            .we    (wr_ok && enable[b]),
            .waddr (id_offset[AW-1:0]),
            .wbit  (din[b]),
            .raddr (rd_idx[4 +: AW]),
            .rbit  (bank_rbit[b])
        );
    end

    assign rd_bit = bank_rbit[rd_idx[3:0]];
    assign busy   = (state == DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (start) state_nxt = DRAIN;
            DRAIN:   if (accept_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= FILL;
        else        state <= state_nxt;
    end

    // Once rd_idx reaches len_q the register simply empties; the accepted
    // last bit coincides with that, so no separate exit path is needed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_q     <= '0;
            rd_idx    <= '0;
            dout      <= 1'b0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else begin
            if (start) begin
                len_q  <= m_len;
                rd_idx <= '0;
            end
            if (take) begin
                if (more) begin
                    dout      <= rd_bit;
                    dout_vld  <= 1'b1;
                    dout_last <= (rd_idx == len_q - LEN_W'(1));
                    rd_idx    <= rd_idx + LEN_W'(1);
                end else begin
                    dout_vld  <= 1'b0;
                    dout_last <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err <= 1'b0;
        end else if ((state == FILL  && ((wen && !offset_ok) || (blk_done && !len_ok))) ||
                     (state == DRAIN && (wen || blk_done))) begin
            err <= 1'b1;
        end
    end
endmodule
